// File: rtl/axi_modport.sv
// AXI slave over an internal byte-addressed memory.
// Write path (AW/W/B) and read path (AR/R) are two independent FSMs that
// share only the storage array. Every channel output is registered.
// Bursts with bad parameters, or that touch any address past the end of the
// memory, are answered with SLVERR for every beat. Such write bursts leave the
// memory untouched, and such read bursts return zero data.
module axi_modport #(
  parameter int ID_X_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // AW channel
  input  logic [ID_X_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  // W channel
  input  logic [ID_X_WIDTH-1:0]   wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  // B channel
  output logic [ID_X_WIDTH-1:0]   bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  // AR channel
  input  logic [ID_X_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  // R channel
  output logic [ID_X_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_WORDS);
  // Wide enough that address + full burst length can never overflow.
  localparam int EW    = ADDR_WIDTH + 12;
  localparam logic [EW-1:0] MEM_BYTES = EW'(MEM_WORDS) * EW'(BYTES);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // --------------------------------------------------------------------------
  // Burst helpers
  // --------------------------------------------------------------------------

  // Word index of a byte address.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_W'(addr >> OFF);
  endfunction

  // Address of the beat following 'addr' in a burst of the given shape.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] mask;
    step = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      BURST_INCR: next_addr = addr + step;
      BURST_WRAP: next_addr = (addr & ~mask) | ((addr + step) & mask);
      default:    next_addr = addr;
    endcase
  endfunction

  // Whole-burst legality: decided once at the address handshake so that a
  // failing write can be suppressed from its very first beat.
  function automatic logic burst_err(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [EW-1:0] lo;
    logic [EW-1:0] hi;
    logic [EW-1:0] total;
    logic          shape_bad;
    lo    = EW'(addr);
    total = (EW'(len) + EW'(1)) << size;
    case (burst)
      BURST_FIXED: hi = lo;
      BURST_INCR:  hi = lo + (EW'(len) << size);
      BURST_WRAP: begin
        lo = lo & ~(total - EW'(1));
        hi = lo + total - EW'(1);
      end
      default:     hi = lo;
    endcase
    shape_bad = (burst == 2'b11)
             || ((burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}))
             || (size > 3'(OFF));
    return shape_bad || (hi >= MEM_BYTES);
  endfunction

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS] = '{default: '0};

  // --------------------------------------------------------------------------
  // Write FSM
  // --------------------------------------------------------------------------

  logic [1:0]            w_state;
  logic [ID_X_WIDTH-1:0] w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic [7:0]            w_beat;
  logic                  w_err;
  logic                  w_last_beat;
  logic                  aw_err;
  logic                  mem_we;

  assign aw_err      = burst_err(awaddr, awlen, awsize, awburst);
  assign w_last_beat = (w_beat == w_len);
  assign mem_we      = (w_state == W_DATA) && wready && wvalid && !w_err;

  // Write address capture, beat sequencing and response generation.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_beat  <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awready && awvalid) begin
            w_id    <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_err   <= aw_err;
            w_beat  <= '0;
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            w_beat <= w_beat + 8'd1;
            // The burst ends at whichever comes first: the expected final
            // beat or wlast. A mismatch between the two is a protocol error.
            if (w_last_beat || wlast) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bid     <= w_id;
              bresp   <= (w_err || (wlast != w_last_beat)) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Byte-lane write into the storage array.
  // NOTE: the array has no reset; contents survive aresetn, and leaving it
  // out of the reset network keeps it mappable onto block RAM.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) begin
          mem[word_idx(w_addr)][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read FSM
  // --------------------------------------------------------------------------

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [7:0]            r_beat;
  logic                  r_err;
  logic                  ar_err;

  assign ar_err = burst_err(araddr, arlen, arsize, arburst);

  // Read address capture and beat presentation. rdata is fetched with a
  // registered read, so a same-cycle write to the same word is not visible
  // until the following beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rresp   <= RESP_OKAY;
      rdata   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_beat  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arready && arvalid) begin
            rid     <= arid;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_err   <= ar_err;
            r_beat  <= '0;
            r_addr  <= next_addr(araddr, arlen, arsize, arburst);
            rdata   <= ar_err ? '0 : mem[word_idx(araddr)];
            rresp   <= ar_err ? RESP_SLVERR : RESP_OKAY;
            rlast   <= (arlen == 8'd0);
            rvalid  <= 1'b1;
            arready <= 1'b0;
            r_state <= R_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          // Outputs only move on a handshake, so they hold while stalled.
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              rdata  <= r_err ? '0 : mem[word_idx(r_addr)];
              rlast  <= ((r_beat + 8'd1) == r_len);
              r_beat <= r_beat + 8'd1;
              r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // The W channel ID is not used by this slave.
  logic unused_wid;
  assign unused_wid = ^wid;

endmodule

// File: tb/tb_axi_modport.sv
// Directed self-checking bench for axi_modport (32-bit data, 1024 words).
module tb_axi_modport;

  localparam int IDW = 8;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MW  = 1024;
  localparam int TMO = 100;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic [IDW-1:0] awid = '0;
  logic [AW-1:0]  awaddr = '0;
  logic [7:0]     awlen = '0;
  logic [2:0]     awsize = '0;
  logic [1:0]     awburst = '0;
  logic           awvalid = 1'b0;
  logic           awready;
  logic [IDW-1:0] wid = '0;
  logic [DW-1:0]  wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic           wlast = 1'b0;
  logic           wvalid = 1'b0;
  logic           wready;
  logic [IDW-1:0] bid;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready = 1'b0;
  logic [IDW-1:0] arid = '0;
  logic [AW-1:0]  araddr = '0;
  logic [7:0]     arlen = '0;
  logic [2:0]     arsize = '0;
  logic [1:0]     arburst = '0;
  logic           arvalid = 1'b0;
  logic           arready;
  logic [IDW-1:0] rid;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic           rvalid;
  logic           rready = 1'b0;

  always #5 aclk = ~aclk;

  axi_modport #(
    .ID_X_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  int checks = 0;
  int failures = 0;

  logic [DW-1:0]  wbuf   [16];
  logic [DW-1:0]  rbuf   [16];
  logic [1:0]     rrbuf  [16];
  logic           rlbuf  [16];
  logic [IDW-1:0] ridbuf [16];
  logic [1:0]     b_resp;
  logic [IDW-1:0] b_id;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic aw_hs(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                       input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    int n;
    n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    awvalid = 1'b1;
    while (!awready && n < TMO) begin tick(); n++; end
    check("aw_wait", 64'(n < TMO), 64'd1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [DW-1:0] data, input logic [DW/8-1:0] strb, input logic last);
    int n;
    n = 0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    while (!wready && n < TMO) begin tick(); n++; end
    check("w_wait", 64'(n < TMO), 64'd1);
    tick();
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic b_wait();
    int n;
    n = 0;
    bready = 1'b1;
    while (!bvalid && n < TMO) begin tick(); n++; end
    check("b_wait", 64'(n < TMO), 64'd1);
    b_resp = bresp;
    b_id   = bid;
    tick();
    bready = 1'b0;
  endtask

  task automatic ar_hs(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                       input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    int n;
    n = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    while (!arready && n < TMO) begin tick(); n++; end
    check("ar_wait", 64'(n < TMO), 64'd1);
    tick();
    arvalid = 1'b0;
  endtask

  task automatic r_beats(input int nb);
    int n;
    rready = 1'b1;
    for (int i = 0; i < nb; i++) begin
      n = 0;
      while (!rvalid && n < TMO) begin tick(); n++; end
      check("r_wait", 64'(n < TMO), 64'd1);
      rbuf[i] = rdata; rrbuf[i] = rresp; rlbuf[i] = rlast; ridbuf[i] = rid;
      tick();
    end
    rready = 1'b0;
  endtask

  task automatic do_write(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nb,
                          input logic [DW/8-1:0] strb);
    aw_hs(id, addr, len, size, burst);
    for (int i = 0; i < nb; i++) w_beat(wbuf[i], strb, i == nb - 1);
    b_wait();
  endtask

  task automatic do_read(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    ar_hs(id, addr, len, size, burst);
    r_beats(int'(len) + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_wready",  64'(wready),  64'd0);
    check("rst_bvalid",  64'(bvalid),  64'd0);
    check("rst_rvalid",  64'(rvalid),  64'd0);
    check("rst_rlast",   64'(rlast),   64'd0);
    check("rst_rdata",   64'(rdata),   64'd0);
    check("rst_bresp",   64'(bresp),   64'd0);
    aresetn = 1'b1;
    check("rel_awready_pre", 64'(awready), 64'd0);
    tick();
    check("rel_awready", 64'(awready), 64'd1);
    check("rel_arready", 64'(arready), 64'd1);

    // INCR write 0x10, four beats, then read back
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
    do_write(8'h5A, 32'h10, 8'd3, 3'd2, 2'b01, 4, 4'hF);
    check("incr_w_bresp", 64'(b_resp), 64'd0);
    check("incr_w_bid",   64'(b_id),   64'h5A);
    do_read(8'h33, 32'h10, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("incr_r_data%0d", i), 64'(rbuf[i]), 64'hA0 + 64'(i));
      check($sformatf("incr_r_last%0d", i), 64'(rlbuf[i]), 64'(i == 3));
      check($sformatf("incr_r_resp%0d", i), 64'(rrbuf[i]), 64'd0);
    end
    check("incr_r_id", 64'(ridbuf[0]), 64'h33);

    // WRAP read: 0x18,0x1C,0x10,0x14 -> A2,A3,A0,A1
    do_read(8'h07, 32'h18, 8'd3, 3'd2, 2'b10);
    check("wrap_d0", 64'(rbuf[0]), 64'hA2);
    check("wrap_d1", 64'(rbuf[1]), 64'hA3);
    check("wrap_d2", 64'(rbuf[2]), 64'hA0);
    check("wrap_d3", 64'(rbuf[3]), 64'hA1);
    check("wrap_resp", 64'(rrbuf[3]), 64'd0);

    // Partial strobe into a zero word
    wbuf[0] = 32'hDEADBEEF;
    do_write(8'h01, 32'h40, 8'd0, 3'd2, 2'b01, 1, 4'b0011);
    check("strb_bresp", 64'(b_resp), 64'd0);
    do_read(8'h02, 32'h40, 8'd0, 3'd2, 2'b01);
    check("strb_data", 64'(rbuf[0]), 64'h0000BEEF);
    check("strb_last", 64'(rlbuf[0]), 64'd1);

    // FIXED burst: both beats hit one word, last write wins
    wbuf[0] = 32'h1111_0001; wbuf[1] = 32'h2222_0002;
    do_write(8'h03, 32'h60, 8'd1, 3'd2, 2'b00, 2, 4'hF);
    check("fixed_bresp", 64'(b_resp), 64'd0);
    do_read(8'h04, 32'h60, 8'd1, 3'd2, 2'b00);
    check("fixed_d0", 64'(rbuf[0]), 64'h2222_0002);
    check("fixed_d1", 64'(rbuf[1]), 64'h2222_0002);

    // Error writes: reserved burst type and address past memory end
    wbuf[0] = 32'h12345678;
    do_write(8'h0E, 32'h40, 8'd0, 3'd2, 2'b11, 1, 4'hF);
    check("err_burst_bresp", 64'(b_resp), 64'd2);
    check("err_burst_bid",   64'(b_id),   64'h0E);
    do_read(8'h05, 32'h40, 8'd0, 3'd2, 2'b01);
    check("err_burst_mem", 64'(rbuf[0]), 64'h0000BEEF);
    do_write(8'h0F, 32'(MW * 4), 8'd0, 3'd2, 2'b01, 1, 4'hF);
    check("err_oob_bresp", 64'(b_resp), 64'd2);
    do_read(8'h06, 32'h0, 8'd0, 3'd2, 2'b01);
    check("err_oob_word0", 64'(rbuf[0]), 64'd0);

    // Early wlast on a 4-beat burst
    wbuf[0] = 32'h5; wbuf[1] = 32'h6;
    do_write(8'h10, 32'h80, 8'd3, 3'd2, 2'b01, 2, 4'hF);
    check("early_wlast_bresp", 64'(b_resp), 64'd2);

    // Error reads
    do_read(8'h11, 32'h10, 8'd1, 3'd2, 2'b11);
    check("rerr_burst_r0", 64'(rrbuf[0]), 64'd2);
    check("rerr_burst_d0", 64'(rbuf[0]),  64'd0);
    check("rerr_burst_r1", 64'(rrbuf[1]), 64'd2);
    check("rerr_burst_l1", 64'(rlbuf[1]), 64'd1);
    do_read(8'h12, 32'(MW * 4), 8'd0, 3'd2, 2'b01);
    check("rerr_oob_resp", 64'(rrbuf[0]), 64'd2);
    check("rerr_oob_data", 64'(rbuf[0]),  64'd0);
    do_read(8'h13, 32'h18, 8'd2, 3'd2, 2'b10);
    check("rerr_wraplen_resp", 64'(rrbuf[2]), 64'd2);
    check("rerr_wraplen_data", 64'(rbuf[0]),  64'd0);

    // Read back-pressure: outputs stable while rready is low
    ar_hs(8'h20, 32'h10, 8'd1, 3'd2, 2'b01);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall_valid%0d", k), 64'(rvalid), 64'd1);
      check($sformatf("stall_data%0d", k),  64'(rdata),  64'hA0);
      check($sformatf("stall_last%0d", k),  64'(rlast),  64'd0);
      tick();
    end
    r_beats(2);
    check("stall_d0", 64'(rbuf[0]), 64'hA0);
    check("stall_d1", 64'(rbuf[1]), 64'hA1);
    check("stall_l1", 64'(rlbuf[1]), 64'd1);

    // Reset in the middle of a write and a read burst
    aw_hs(8'h21, 32'h200, 8'd1, 3'd2, 2'b01);
    w_beat(32'h11111111, 4'hF, 1'b0);
    ar_hs(8'h22, 32'h10, 8'd3, 3'd2, 2'b01);
    check("mid_rvalid", 64'(rvalid), 64'd1);
    check("mid_wready", 64'(wready), 64'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check("arst_rvalid",  64'(rvalid),  64'd0);
    check("arst_wready",  64'(wready),  64'd0);
    check("arst_bvalid",  64'(bvalid),  64'd0);
    check("arst_awready", 64'(awready), 64'd0);
    check("arst_rdata",   64'(rdata),   64'd0);
    tick();
    aresetn = 1'b1;
    check("arst_rel_pre", 64'(arready), 64'd0);
    tick();
    check("arst_rel_awready", 64'(awready), 64'd1);
    check("arst_rel_arready", 64'(arready), 64'd1);
    check("arst_no_bvalid",   64'(bvalid),  64'd0);
    do_read(8'h23, 32'h200, 8'd1, 3'd2, 2'b01);
    check("partial_d0", 64'(rbuf[0]), 64'h11111111);
    check("partial_d1", 64'(rbuf[1]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
